// File: rtl/counter_readout.sv
// -----------------------------------------------------------------------------
// counter_readout
//
// This block reads out the event counter bank. When a readout request
// arrives, it copies every 48-bit counter into a snapshot register in one
// cycle. It then sends the snapshot out as a framed stream of 32-bit words.
//
// Packet layout (2 + 2*NCOUNTERS words):
//   HDR : {HDR_MAGIC, seq, NCOUNTERS[7:0], 8'h00}
//   CHI : {CNT_TAG, idx[7:0], snap[idx][47:32]}    one per counter
//   CLO : snap[idx][31:0]                          one per counter
//   TRL : {TRL_MAGIC, checksum[23:0]}              m_tlast = 1
// The checksum is the XOR of every word sent before the trailer.
//
// Stream handshake (valid/ready):
//   - A word transfers on a rising clk edge where m_tvalid & m_tready.
//   - Once m_tvalid is raised, it stays high until a transfer happens.
//   - While m_tvalid=1 and m_tready=0, m_tdata and m_tlast stay stable.
//     They are decoded only from registered state, so they cannot change
//     during a stall.
//   - After the trailer transfers, there is at least one IDLE cycle with
//     m_tvalid=0 before the next header.
//
// Requests:
//   - req is sampled as a level on every cycle.
//   - In IDLE, a request (or a pending one) starts a packet.
//   - While a packet is in progress, the first request is stored as pending.
//   - Any further request while pending is set increments the saturating
//     'dropped' counter.
//
// Optional feature (macro COUNTER_READOUT_CLEAR_EN):
//   - Defined: load is driven all ones for one cycle, starting the cycle
//     after the snapshot edge, so the counter bank clears or reloads.
//   - Undefined: load is tied to zero and the counters run freely.
//
// Ports:
//   clk       in   backend clock
//   rst       in   synchronous active-low reset
//   counters  in   packed counters; counter i is at [i*48 +: 48]
//   req       in   readout request (level)
//   load      out  per-counter load/clear strobe
//   m_tdata   out  stream data
//   m_tvalid  out  stream valid
//   m_tready  in   stream ready
//   m_tlast   out  high on the trailer word
//   busy      out  packet in progress (registered, state != IDLE)
//   seq       out  sequence number of the next or current packet
//   dropped   out  number of lost requests (saturating)
// -----------------------------------------------------------------------------
module counter_readout #(
    parameter int         NCOUNTERS = 3,
    parameter logic [7:0] HDR_MAGIC = 8'hA5,
    parameter logic [7:0] CNT_TAG   = 8'hC0,
    parameter logic [7:0] TRL_MAGIC = 8'h5A
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCOUNTERS*48-1:0] counters,
    input  logic                    req,
    output logic [NCOUNTERS-1:0]    load,
    output logic [31:0]             m_tdata,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic                    busy,
    output logic [7:0]              seq,
    output logic [15:0]             dropped
);

    localparam int               IDX_W     = (NCOUNTERS > 1) ? $clog2(NCOUNTERS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NCOUNTERS - 1);
    localparam logic [7:0]       NCNT_BYTE = 8'(NCOUNTERS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_CHI  = 3'd2,
        S_CLO  = 3'd3,
        S_TRL  = 3'd4
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [47:0]      snap_q [NCOUNTERS];
    logic [23:0]      checksum_q, checksum_d;
    logic [7:0]       seq_q, seq_d;
    logic             pending_q, pending_d;
    logic [15:0]      dropped_q, dropped_d;
    logic             busy_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        capture;     // snapshot edge: IDLE and (req or pending)
    logic        xfer;        // a word transfers at the coming edge
    logic        valid_w;
    logic [31:0] word;
    logic        word_last;
    logic [47:0] snap_cur;
    logic [7:0]  idx_byte;

    assign snap_cur = snap_q[idx_q];
    assign idx_byte = 8'(idx_q);
    assign valid_w  = (state_q != S_IDLE);
    assign xfer     = valid_w & m_tready;

    // Word decode. It depends only on registered state, so the presented
    // word cannot change while the sink holds off.
    always_comb begin
        word      = 32'h0;
        word_last = 1'b0;
        unique case (state_q)
            S_IDLE: word = 32'h0;
            S_HDR:  word = {HDR_MAGIC, seq_q, NCNT_BYTE, 8'h00};
            S_CHI:  word = {CNT_TAG, idx_byte, snap_cur[47:32]};
            S_CLO:  word = snap_cur[31:0];
            S_TRL: begin
                word      = {TRL_MAGIC, checksum_q};
                word_last = 1'b1;
            end
            default: word = 32'h0;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        checksum_d = checksum_q;
        seq_d      = seq_q;
        pending_d  = pending_q;
        dropped_d  = dropped_q;
        capture    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req || pending_q) begin
                    // Starting a packet uses up both the live request and
                    // any pending one.
                    capture    = 1'b1;
                    state_d    = S_HDR;
                    idx_d      = '0;
                    pending_d  = 1'b0;
                    checksum_d = '0;
                end
            end
            S_HDR: begin
                if (xfer) state_d = S_CHI;
            end
            S_CHI: begin
                if (xfer) state_d = S_CLO;
            end
            S_CLO: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_TRL;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_CHI;
                    end
                end
            end
            S_TRL: begin
                if (xfer) begin
                    state_d = S_IDLE;
                    seq_d   = seq_q + 8'd1;   // wraps 255 -> 0
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every word before the trailer goes into the checksum. In IDLE
        // no transfer can happen, so the clear above takes effect there.
        if (xfer && (state_q != S_TRL)) begin
            checksum_d = checksum_q ^ word[23:0];
        end

        // Requests that arrive while a packet is in progress. This also
        // covers the trailer-transfer cycle, so that request becomes the
        // next packet.
        if ((state_q != S_IDLE) && req) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (dropped_q != 16'hFFFF) begin
                dropped_d = dropped_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            checksum_q <= '0;
            seq_q      <= '0;
            pending_q  <= 1'b0;
            dropped_q  <= '0;
            busy_q     <= 1'b0;
            for (int i = 0; i < NCOUNTERS; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            checksum_q <= checksum_d;
            seq_q      <= seq_d;
            pending_q  <= pending_d;
            dropped_q  <= dropped_d;
            busy_q     <= (state_d != S_IDLE);
            if (capture) begin
                for (int i = 0; i < NCOUNTERS; i++) begin
                    snap_q[i] <= counters[i*48 +: 48];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Counter-bank load strobe
    // ------------------------------------------------------------------
`ifdef COUNTER_READOUT_CLEAR_EN
    logic [NCOUNTERS-1:0] load_q;

    // The strobe is registered from the capture decision, so it is high
    // only in the cycle right after the snapshot edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            load_q <= '0;
        end else begin
            load_q <= {NCOUNTERS{capture}};
        end
    end

    assign load = load_q;
`else
    assign load = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_tdata  = word;
    assign m_tvalid = valid_w;
    assign m_tlast  = word_last;
    assign busy     = busy_q;
    assign seq      = seq_q;
    assign dropped  = dropped_q;

endmodule

// File: tb/tb_counter_readout.sv
// -----------------------------------------------------------------------------
// tb_counter_readout
//
// Directed bench for counter_readout with NCOUNTERS=3.
//
// Table-driven part:
//   - Each row holds the counter values, the sink behaviour (free-running or
//     backpressure) and the eight hand-computed packet words.
//   - Each row is checked word by word through an expected queue.
//
// Hand-written sequences:
//   - pending request and dropped count
//   - idle gap between back-to-back packets
//   - reset in the middle of a packet
//   - load strobe pattern
// -----------------------------------------------------------------------------
module tb_counter_readout;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic         clk      = 1'b0;
    logic         rst      = 1'b0;
    logic         req      = 1'b0;
    logic         m_tready = 1'b1;
    logic [143:0] counters = '0;
    logic [2:0]   load;
    logic [31:0]  m_tdata;
    logic         m_tvalid;
    logic         m_tlast;
    logic         busy;
    logic [7:0]   seq;
    logic [15:0]  dropped;

    always #5 clk = ~clk;

    counter_readout #(
        .NCOUNTERS (3),
        .HDR_MAGIC (8'hA5),
        .CNT_TAG   (8'hC0),
        .TRL_MAGIC (8'h5A)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .counters (counters),
        .req      (req),
        .load     (load),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .busy     (busy),
        .seq      (seq),
        .dropped  (dropped)
    );

`ifdef COUNTER_READOUT_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Vector table and scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic            do_rst;     // reset before this row
        logic            bp;         // toggle ready plus a 5-cycle stall
        logic [143:0]    cnt;        // counter bus value
        logic [7:0][31:0] w;         // expected words, w[0] = header
        logic [7:0]      seq_after;  // expected seq once the packet is done
    } case_t;

    case_t       cases [3];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];
    logic        last_q [$];
    int          cyc_q [$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Driver: runs the sink and req for up to 300 cycles, records every
    //         transferred word, and stops after npkts trailers.
    // ------------------------------------------------------------------
    task automatic collect(input logic [143:0] cnt, input logic bp,
                           input int req_mask, input int npkts);
        int          cyc;
        int          done;
        int          stall_left;
        int          last_trl;
        int          load_bad;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [2:0]  exp_load;
        cyc        = 0;
        done       = 0;
        stall_left = 5;
        last_trl   = -10;
        load_bad   = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        got_q.delete();
        last_q.delete();
        cyc_q.delete();
        counters = cnt;
        while (done < npkts && cyc < 300) begin
            @(negedge clk);
            req = (cyc < 32) ? req_mask[cyc] : 1'b0;
            if (bp && m_tvalid && got_q.size() == 2 && stall_left > 0) begin
                m_tready = 1'b0;   // long stall on the first CLO word
                stall_left--;
            end else if (bp) begin
                m_tready = cyc[0];
            end else begin
                m_tready = 1'b1;
            end
            if (prev_stall) begin
                check("stall_valid_held", 32'(m_tvalid), 32'd1);
                check("stall_data_held", m_tdata, prev_data);
                check("stall_last_held", 32'(m_tlast), 32'(prev_last));
            end
            // The strobe is expected one cycle after each capture edge:
            // the first capture is at the end of cycle 0, and a later one
            // is one idle cycle after each trailer transfer.
            exp_load = (CLR_EN && (cyc == 1 || (cyc == last_trl + 2 && done < npkts)))
                       ? 3'b111 : 3'b000;
            if (load !== exp_load) begin
                if (load_bad == 0) begin
                    $display("FAIL load_cycle%0d: got %b, expected %b", cyc, load, exp_load);
                end
                load_bad++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (m_tvalid && m_tready) begin
                got_q.push_back(m_tdata);
                last_q.push_back(m_tlast);
                cyc_q.push_back(cyc);
                if (m_tlast) begin
                    done++;
                    last_trl = cyc;
                end
            end
            cyc++;
        end
        req = 1'b0;
        check("packets_within_budget", 32'(done), 32'(npkts));
        check("load_pattern", 32'(load_bad), 32'd0);
    endtask

    // Compares 8 recorded words, starting at base, against an expected packet.
    task automatic check_packet(input int pk, input logic [7:0][31:0] w, input int base);
        logic [31:0] e;
        for (int k = 0; k < 8; k++) exp_q.push_back(w[k]);
        for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            if (base + k < got_q.size()) begin
                check($sformatf("pkt%0d_word%0d", pk, k), got_q[base+k], e);
                check($sformatf("pkt%0d_last%0d", pk, k), 32'(last_q[base+k]),
                      (k == 7) ? 32'd1 : 32'd0);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        req      = 1'b0;
        m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
        check({tag, "_tlast"}, 32'(m_tlast), 32'd0);
        check({tag, "_tdata"}, m_tdata, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_seq"}, 32'(seq), 32'd0);
        check({tag, "_dropped"}, 32'(dropped), 32'd0);
        check({tag, "_load"}, 32'(load), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [7:0][31:0] p1;
        logic [7:0][31:0] p2;
        int               found;

        // Row 0: counters 1,2,3. XOR of words 0..6 = 65030300.
        cases[0].do_rst    = 1'b0;
        cases[0].bp        = 1'b0;
        cases[0].cnt       = {48'h3, 48'h2, 48'h1};
        cases[0].w         = {32'h5A030300, 32'h00000003, 32'hC0020000, 32'h00000002,
                              32'hC0010000, 32'h00000001, 32'hC0000000, 32'hA5000300};
        cases[0].seq_after = 8'd1;
        // Row 1: counter0 = ABCD_1234_5678, seq 1. Low 24 bits of XOR = 36FEB4.
        cases[1].do_rst    = 1'b0;
        cases[1].bp        = 1'b0;
        cases[1].cnt       = {48'h3, 48'h2, 48'hABCD_1234_5678};
        cases[1].w         = {32'h5A36FEB4, 32'h00000003, 32'hC0020000, 32'h00000002,
                              32'hC0010000, 32'h12345678, 32'hC000ABCD, 32'hA5010300};
        cases[1].seq_after = 8'd2;
        // Row 2: after a reset, row 0 again under backpressure, so the
        // words are the same as row 0.
        cases[2]           = cases[0];
        cases[2].do_rst    = 1'b1;
        cases[2].bp        = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            if (cases[i].do_rst) do_reset();
            collect(cases[i].cnt, cases[i].bp, 1, 1);
            check($sformatf("row%0d_len", i), 32'(got_q.size()), 32'd8);
            check_packet(i, cases[i].w, 0);
            if (!cases[i].bp && cyc_q.size() > 0) begin
                check($sformatf("row%0d_first_word_cycle", i), 32'(cyc_q[0]), 32'd1);
            end
            @(negedge clk);
            check($sformatf("row%0d_seq_after", i), 32'(seq), 32'(cases[i].seq_after));
            check($sformatf("row%0d_busy_after", i), 32'(busy), 32'd0);
            check($sformatf("row%0d_tvalid_after", i), 32'(m_tvalid), 32'd0);
        end

        // Pending request: req pulses 2 cycles apart. The first starts a
        // packet, the second becomes pending, the third is dropped. seq = 1 now.
        p1    = cases[0].w;
        p1[0] = 32'hA5010300;
        p1[7] = 32'h5A020300;
        p2    = cases[0].w;
        p2[0] = 32'hA5020300;
        p2[7] = 32'h5A010300;
        collect(cases[0].cnt, 1'b0, 32'b10101, 2);
        check("pending_len", 32'(got_q.size()), 32'd16);
        check_packet(10, p1, 0);
        check_packet(11, p2, 8);
        if (cyc_q.size() >= 9) begin
            check("idle_gap_cycles", 32'(cyc_q[8] - cyc_q[7]), 32'd2);
        end
        @(negedge clk);
        check("pending_dropped", 32'(dropped), 32'd1);
        check("pending_seq_after", 32'(seq), 32'd3);

        // Reset while the CHI word of counter 1 is presented.
        counters = cases[0].cnt;
        m_tready = 1'b1;
        req      = 1'b1;
        found    = 0;
        for (int c = 0; c < 30 && found == 0; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (m_tvalid && m_tdata == 32'hC0010000) found = 1;
        end
        check("midreset_reached_chi1", 32'(found), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_idle("midreset");
        rst = 1'b1;
        collect(cases[0].cnt, 1'b0, 1, 1);
        check("midreset_len", 32'(got_q.size()), 32'd8);
        check_packet(20, cases[0].w, 0);
        @(negedge clk);
        check("midreset_seq_after", 32'(seq), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/counter_readout.md
Name: counter_readout

Overview:
- Downstream consumer of the event counter bank's packed `counters` bus.
- On a readout request, snapshots all NCOUNTERS 48-bit counters in one cycle.
- Serializes the snapshot into a framed 32-bit word stream with valid/ready/last handshake for the backend link/packetizer.
- Single clock domain (backend `clk`). Counters are already in `clk` domain.

Parameters:
- NCOUNTERS, 3, number of 48-bit counters on the input bus (1..255)
- HDR_MAGIC, 8'hA5, top byte of header word
- CNT_TAG, 8'hC0, top byte of each counter high word
- TRL_MAGIC, 8'h5A, top byte of trailer word

Ports:
- clk  in  1  backend clock
- rst  in  1  synchronous active-low reset (0 = reset, sampled on rising clk)
- counters  in  NCOUNTERS*48  packed counter values; counter i at [i*48 +: 48]
- req  in  1  readout request, level-sampled each cycle
- load  out  NCOUNTERS  per-counter load/clear strobe to the event counter bank
- m_tdata  out  32  stream data
- m_tvalid  out  1  stream valid
- m_tready  in  1  stream ready
- m_tlast  out  1  marks trailer word
- busy  out  1  packet in progress (state != IDLE)
- seq  out  8  sequence number of the next/current packet
- dropped  out  16  requests lost because one was already pending; saturating

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE; m_tvalid=0, m_tlast=0, m_tdata=0, load=0, busy=0, seq=0, dropped=0, pending=0, snapshot=0, checksum=0. Reset mid-packet aborts immediately. No trailer is emitted.
- States: IDLE, HDR, CHI, CLO, TRL. Index register idx counts 0..NCOUNTERS-1.
- IDLE: if req=1 or pending=1 at an edge:
  - snapshot<=counters, idx<=0, pending<=0, state<=HDR.
  - m_tvalid=1 starting the next cycle, so response latency is 1 cycle.
- Word formats:
  - HDR: {HDR_MAGIC, seq, NCOUNTERS[7:0], 8'h00}
  - CHI: {CNT_TAG, idx[7:0], snap[idx][47:32]}
  - CLO: snap[idx][31:0]
  - TRL: {TRL_MAGIC, checksum[23:0]}, where checksum = XOR of all preceding words in the packet
- Transitions occur only on a transfer (m_tvalid & m_tready):
  - HDR -> CHI.
  - CHI -> CLO.
  - CLO -> CHI with idx+1, or -> TRL if idx = NCOUNTERS-1.
  - TRL -> IDLE, with seq<=seq+1 (wraps 255 -> 0).
- Packet length is always 2 + 2*NCOUNTERS words. m_tlast=1 only in TRL.
- Stream rules:
  - While m_tvalid=1 and m_tready=0, m_tdata and m_tlast are held stable.
  - m_tvalid never deasserts without a transfer.
  - Back-to-back packets: after the TRL transfer, one IDLE cycle with m_tvalid=0, then the next HDR.
- Requests while busy:
  - The first request sets pending=1.
  - Further requests while pending=1 increment `dropped`, saturating at 16'hFFFF.
  - req held high continuously counts as one request per cycle.
  - A req in the same cycle as the TRL transfer sets pending.
- load=0 at all times unless the optional feature is compiled in.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: COUNTER_READOUT_CLEAR_EN.
- Defined: in the cycle the snapshot is captured, load is driven all ones for exactly one clk cycle, the cycle after the capture edge. This clears/reloads the counters, so the next packet reports counts since this read. Events landing in the strobe cycle belong to the counter bank's semantics.
- Undefined: load is tied to 0. Counters are free-running and consecutive packets show cumulative values.

Test Plan:
- Reset, NCOUNTERS=3, counters={48'h3,48'h2,48'h1}, single req pulse, m_tready=1 -> 8 words: A5000300, C0000000, 00000001, C0010000, 00000002, C0020000, 00000003, trailer {5A, XOR[23:0]}; tlast on word 8 only; seq becomes 1.
- counter0=48'hABCD_1234_5678 -> CHI word C000ABCD, CLO word 12345678.
- Backpressure: m_tready toggled 1/0 every cycle plus a 5-cycle low stall during CLO -> m_tdata/m_tlast stable while stalled; 8 words total, identical to the unstalled run.
- req pulses at cycles 2, 4, 6 of a packet -> pending serviced as a second packet with header seq=1; dropped=1.
- rst=0 asserted during the CHI of counter 1 -> next cycle m_tvalid=0, busy=0, seq=0; a new req yields a clean packet with seq 0.
- With COUNTER_READOUT_CLEAR_EN: req -> load=3'b111 for exactly 1 cycle, one cycle after the request edge; without the macro, load remains 0 throughout.
